// File: rtl/sc_scoredisplay.sv
// Score display: converts each new 6-bit score to BCD with a sequential
// shift-add-3 engine, drives two active-low 7-segment digits and keeps the high score.
module sc_scoredisplay (
  input  logic       SC_SCOREDISPLAY_CLOCK_50,
  input  logic       SC_SCOREDISPLAY_RESET_InHigh,
  input  logic [5:0] SC_SCOREDISPLAY_Score_InBus,
  output logic [3:0] SC_SCOREDISPLAY_Tens_OutBus,
  output logic [3:0] SC_SCOREDISPLAY_Units_OutBus,
  output logic [3:0] SC_SCOREDISPLAY_HighTens_OutBus,
  output logic [3:0] SC_SCOREDISPLAY_HighUnits_OutBus,
  output logic [6:0] SC_SCOREDISPLAY_Hex1_OutBus,
  output logic [6:0] SC_SCOREDISPLAY_Hex0_OutBus,
  output logic       SC_SCOREDISPLAY_Busy_Out,
  output logic       SC_SCOREDISPLAY_NewHigh_Out
);

  // state   | meaning
  // S_IDLE  | waiting for the score bus to differ from the last snapshot
  // S_SHIFT | six add-3/shift iterations, one per clock
  // S_DONE  | publish digits, update high score
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_snapshot, r_bin, r_high;
  logic [7:0]  r_bcd;
  logic [2:0]  r_iter;
  logic [3:0]  r_tens, r_units, r_high_tens, r_high_units;
  logic        r_new_high;
  logic [7:0]  w_bcd_adj;
  logic [13:0] w_shift;
  logic        w_start;

  assign w_start   = (SC_SCOREDISPLAY_Score_InBus != r_snapshot);
  assign w_bcd_adj = {(r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4],
                      (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0]};
  assign w_shift   = {w_bcd_adj, r_bin};

  always_ff @(posedge SC_SCOREDISPLAY_CLOCK_50 or posedge SC_SCOREDISPLAY_RESET_InHigh) begin
    if (SC_SCOREDISPLAY_RESET_InHigh) r_state <= S_IDLE;
    else                              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_SHIFT;
      S_SHIFT: if (r_iter == 3'd5) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge SC_SCOREDISPLAY_CLOCK_50 or posedge SC_SCOREDISPLAY_RESET_InHigh) begin
    if (SC_SCOREDISPLAY_RESET_InHigh) begin
      r_snapshot   <= '0;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_iter       <= '0;
      r_tens       <= '0;
      r_units      <= '0;
      r_high       <= '0;
      r_high_tens  <= '0;
      r_high_units <= '0;
      r_new_high   <= 1'b0;
    end else begin
      r_new_high <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_snapshot <= SC_SCOREDISPLAY_Score_InBus;
            r_bin      <= SC_SCOREDISPLAY_Score_InBus;
            r_bcd      <= '0;
            r_iter     <= '0;
          end
        end
        S_SHIFT: begin
          r_bcd  <= w_shift[12:5];
          r_bin  <= {w_shift[4:0], 1'b0};
          r_iter <= r_iter + 3'd1;
        end
        S_DONE: begin
          r_tens  <= r_bcd[7:4];
          r_units <= r_bcd[3:0];
          if (r_snapshot > r_high) begin
            r_high       <= r_snapshot;
            r_high_tens  <= r_bcd[7:4];
            r_high_units <= r_bcd[3:0];
            r_new_high   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Leading-zero blanking applies to the tens digit only
  assign SC_SCOREDISPLAY_Hex1_OutBus      = (r_tens == 4'd0) ? 7'h7F : seg7(r_tens);
  assign SC_SCOREDISPLAY_Hex0_OutBus      = seg7(r_units);
  assign SC_SCOREDISPLAY_Tens_OutBus      = r_tens;
  assign SC_SCOREDISPLAY_Units_OutBus     = r_units;
  assign SC_SCOREDISPLAY_HighTens_OutBus  = r_high_tens;
  assign SC_SCOREDISPLAY_HighUnits_OutBus = r_high_units;
  assign SC_SCOREDISPLAY_Busy_Out         = (r_state != S_IDLE);
  assign SC_SCOREDISPLAY_NewHigh_Out      = r_new_high;

endmodule

// File: tb/tb_sc_scoredisplay.sv
// Bench for sc_scoredisplay: arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then a sweep and random stimulus.
module tb_sc_scoredisplay;

  logic       clk, rst;
  logic [5:0] bus;
  logic [3:0] tens, units, htens, hunits;
  logic [6:0] hex1, hex0;
  logic       busy, newhigh;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_last = 0, m_cnt = 0, m_tens = 0, m_units = 0, m_high = 0;
  bit m_busy = 0, m_newhigh = 0;

  sc_scoredisplay dut (
    .SC_SCOREDISPLAY_CLOCK_50        (clk),
    .SC_SCOREDISPLAY_RESET_InHigh    (rst),
    .SC_SCOREDISPLAY_Score_InBus     (bus),
    .SC_SCOREDISPLAY_Tens_OutBus     (tens),
    .SC_SCOREDISPLAY_Units_OutBus    (units),
    .SC_SCOREDISPLAY_HighTens_OutBus (htens),
    .SC_SCOREDISPLAY_HighUnits_OutBus(hunits),
    .SC_SCOREDISPLAY_Hex1_OutBus     (hex1),
    .SC_SCOREDISPLAY_Hex0_OutBus     (hex0),
    .SC_SCOREDISPLAY_Busy_Out        (busy),
    .SC_SCOREDISPLAY_NewHigh_Out     (newhigh)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic int seg7(input int d);
    int tbl [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
    if (d < 0 || d > 9) return 'h7F;
    return tbl[d];
  endfunction

  // A conversion of value v accepted at edge k shows v/10, v%10 after edge k+7.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last = 0; m_cnt = 0; m_tens = 0; m_units = 0; m_high = 0;
      m_busy = 0; m_newhigh = 0;
    end else begin
      m_newhigh = 0;
      if (!m_busy) begin
        if (int'(bus) != m_last) begin
          m_last = int'(bus);
          m_busy = 1;
          m_cnt  = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 7) begin
          m_tens  = m_last / 10;
          m_units = m_last % 10;
          if (m_last > m_high) begin
            m_high    = m_last;
            m_newhigh = 1;
          end
          m_busy = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called #1 after a posedge once the bus is set; returns busy cycles and NewHigh pulses.
  task automatic run_conv(output int busy_n, output int nh_n);
    bit done = 0;
    busy_n = 0; nh_n = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (newhigh) nh_n++;
      if (i >= 1 && !busy) done = 1;
    end
    if (!done) chk("conv_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int bn, nh;
    rst = 1'b1;
    bus = 6'd0;

    fork
      forever begin
        @(negedge clk);
        chk("tens",   int'(tens),   m_tens);
        chk("units",  int'(units),  m_units);
        chk("htens",  int'(htens),  m_high / 10);
        chk("hunits", int'(hunits), m_high % 10);
        chk("hex1",   int'(hex1),   (m_tens == 0) ? 'h7F : seg7(m_tens));
        chk("hex0",   int'(hex0),   seg7(m_units));
        chk("busy",   int'(busy),   int'(m_busy));
        chk("newhigh",int'(newhigh),int'(m_newhigh));
      end
    join_none

    step(3);
    @(negedge clk);
    chk("rst_hex1", int'(hex1), 'h7F);
    chk("rst_hex0", int'(hex0), 'h40);
    chk("rst_busy", int'(busy), 0);
    chk("rst_digits", int'({tens, units, htens, hunits}), 0);
    #1 rst = 1'b0;
    step(2);

    bus = 6'd37;
    run_conv(bn, nh);
    chk("37_busy_cycles", bn, 7);
    chk("37_newhigh_pulses", nh, 1);
    chk("37_digits", int'({tens, units}), 'h37);
    chk("37_hex", int'({hex1, hex0}), {7'h30, 7'h78});
    chk("37_high", int'({htens, hunits}), 'h37);

    bus = 6'd63;
    run_conv(bn, nh);
    chk("63_digits", int'({tens, units}), 'h63);
    chk("63_hex", int'({hex1, hex0}), {7'h02, 7'h30});
    chk("63_newhigh_pulses", nh, 1);

    bus = 6'd5;
    run_conv(bn, nh);
    chk("5_hex", int'({hex1, hex0}), {7'h7F, 7'h12});
    chk("5_high", int'({htens, hunits}), 'h63);
    chk("5_newhigh_pulses", nh, 0);

    // change while busy
    bus = 6'd0;
    do_reset();
    step(2);
    bus = 6'd10;           // sampled at edge k
    step(3);               // k, k+1, k+2
    bus = 6'd12;
    step(5);               // k+3 .. k+7
    @(negedge clk);
    chk("busy_chg_first", int'({tens, units}), 'h10);
    step(8);               // k+8 .. k+15
    @(negedge clk);
    chk("busy_chg_second", int'({tens, units}), 'h12);
    chk("busy_chg_high", int'({htens, hunits}), 'h12);
    step(2);

    // reset mid-conversion
    bus = 6'd45;
    step(4);               // k .. k+3
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_digits", int'({tens, units, htens, hunits}), 0);
    chk("midrst_hex", int'({hex1, hex0}), {7'h7F, 7'h40});
    chk("midrst_busy", int'(busy), 0);
    step(1);
    rst = 1'b0;
    step(7);               // first post-release edge .. +6
    @(negedge clk);
    chk("postrst_not_yet", int'({tens, units}), 0);
    step(1);
    @(negedge clk);
    chk("postrst_45", int'({tens, units}), 'h45);

    // exhaustive sweep
    step(1);
    for (int v = 0; v < 64; v++) begin
      bus = 6'(v);
      run_conv(bn, nh);
      chk("sweep_value", int'(tens) * 10 + int'(units), v);
    end
    chk("sweep_high", int'({htens, hunits}), 'h63);

    // random stimulus, including changes while busy
    bus = 6'd0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      bus = 6'($urandom_range(0, 63));
      step($urandom_range(1, 12));
    end
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
